single_cycle_cpu: RTL and testbench

- Single-cycle 32-bit MIPS-style processor: one instruction fetched, decoded, executed and written back per CLK rising edge.
- Contains PC, instruction ROM, 32x32 register file, sign/zero extender, ALU, data RAM and control unit.
- Every internal datapath/control net is exported as an output for waveform debug.
- Top of the CPU subsystem; driven only by CLK and Reset.

---
 rtl/single_cycle_cpu.sv | 178 +++++++++++++++++
 tb/tb_single_cycle_cpu.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/single_cycle_cpu.sv
// Single-cycle 32-bit MIPS-style CPU: PC, instruction ROM, register file, extender, ALU, data RAM, control.
// Ports: CLK, Reset in; every datapath/control net is exported as an output. Optional macro BNE_EN adds bne (110001).
module single_cycle_cpu #(
   parameter int    IMEM_WORDS = 64,
   parameter int    DMEM_WORDS = 64,
   parameter string IMEM_INIT  = ""
) (
   input  logic        CLK,
   input  logic        Reset,
   output logic [31:0] PCout,
   output logic [31:0] PCin,
   output logic [31:0] PCValue,
   output logic [31:0] instruction,
   output logic [5:0]  op,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [15:0] immediate,
   output logic        zero,
   output logic        RegOut,
   output logic        InsMenRW,
   output logic        ExtSel,
   output logic        DataMenRW,
   output logic        ALUM2Reg,
   output logic        ALUSrcB,
   output logic        PCSrc,
   output logic        RegWre,
   output logic        PCWre,
   output logic [2:0]  ALUOp,
   output logic [4:0]  RFSelectorOut,
   output logic [31:0] extendOut,
   output logic [31:0] readData1,
   output logic [31:0] readData2,
   output logic [31:0] ALUSelectorOut,
   output logic [31:0] result,
   output logic [31:0] dataOut,
   output logic [31:0] writeData
);

   localparam int IAW = $clog2(IMEM_WORDS);
   localparam int DAW = $clog2(DMEM_WORDS);

   logic [31:0] imem [IMEM_WORDS];
   logic [31:0] dmem [DMEM_WORDS];
   logic [31:0] rf   [32];
   logic [31:0] pc;
   logic        br_eq;
   logic        br_ne;

   initial begin
      for (int i = 0; i < IMEM_WORDS; i++) imem[i] = '0;
   end

   assign PCout       = pc;
   assign PCValue     = pc + 32'd4;
   assign instruction = imem[pc[IAW+1:2]];
   assign op          = instruction[31:26];
   assign rs          = instruction[25:21];
   assign rt          = instruction[20:16];
   assign rd          = instruction[15:11];
   assign immediate   = instruction[15:0];
   assign InsMenRW    = 1'b0;

   always_comb begin
      RegWre    = 1'b0;
      ALUSrcB   = 1'b0;
      ExtSel    = 1'b0;
      ALUOp     = 3'b000;
      RegOut    = 1'b0;
      ALUM2Reg  = 1'b0;
      DataMenRW = 1'b0;
      PCWre     = 1'b1;
      br_eq     = 1'b0;
      br_ne     = 1'b0;
      case (op)
         6'b000000, 6'b100000: begin
            RegWre = 1'b1;
            RegOut = 1'b1;
         end
         6'b000001: begin
            RegWre  = 1'b1;
            ALUSrcB = 1'b1;
            ExtSel  = 1'b1;
         end
         6'b000010: begin
            RegWre = 1'b1;
            RegOut = 1'b1;
            ALUOp  = 3'b001;
         end
         6'b010000: begin
            RegWre  = 1'b1;
            ALUSrcB = 1'b1;
            ALUOp   = 3'b011;
         end
         6'b010001: begin
            RegWre = 1'b1;
            RegOut = 1'b1;
            ALUOp  = 3'b010;
         end
         6'b010010: begin
            RegWre = 1'b1;
            RegOut = 1'b1;
            ALUOp  = 3'b011;
         end
         6'b100110: begin
            ALUSrcB   = 1'b1;
            ExtSel    = 1'b1;
            DataMenRW = 1'b1;
         end
         6'b100111: begin
            RegWre   = 1'b1;
            ALUSrcB  = 1'b1;
            ExtSel   = 1'b1;
            ALUM2Reg = 1'b1;
         end
         6'b110000: begin
            ExtSel = 1'b1;
            ALUOp  = 3'b001;
            br_eq  = 1'b1;
         end
`ifdef BNE_EN
         6'b110001: begin
            ExtSel = 1'b1;
            ALUOp  = 3'b001;
            br_ne  = 1'b1;
         end
`endif
         6'b111111: PCWre = 1'b0;
         default: ;
      endcase
   end

   // branch decision kept outside the decoder so zero does not feed back into it
   assign PCSrc = (br_eq & zero) | (br_ne & ~zero);

   assign extendOut = ExtSel ? {{16{immediate[15]}}, immediate}
                             : {16'h0000, immediate};
   assign PCin = PCSrc ? PCValue + {extendOut[29:0], 2'b00} : PCValue;

   assign RFSelectorOut  = RegOut ? rd : rt;
   assign readData1      = (rs == 5'd0) ? 32'd0 : rf[rs];
   assign readData2      = (rt == 5'd0) ? 32'd0 : rf[rt];
   assign ALUSelectorOut = ALUSrcB ? extendOut : readData2;

   always_comb begin
      case (ALUOp)
         3'b000:  result = readData1 + ALUSelectorOut;
         3'b001:  result = readData1 - ALUSelectorOut;
         3'b010:  result = readData1 & ALUSelectorOut;
         3'b011:  result = readData1 | ALUSelectorOut;
         3'b100:  result = readData1 << ALUSelectorOut[4:0];
         default: result = 32'd0;
      endcase
   end

   assign zero      = (result == 32'd0);
   assign dataOut   = dmem[result[DAW+1:2]];
   assign writeData = ALUM2Reg ? dataOut : result;

   always_ff @(posedge CLK) begin
      if (Reset) pc <= 32'd0;
      else if (PCWre) pc <= PCin;
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      end else if (RegWre && RFSelectorOut != 5'd0) begin
         rf[RFSelectorOut] <= writeData;
      end
   end

   // data RAM keeps its contents across Reset
   always_ff @(posedge CLK) begin
      if (!Reset && DataMenRW) dmem[result[DAW+1:2]] <= readData2;
   end

endmodule

// File: tb/tb_single_cycle_cpu.sv
// Self-checking bench for single_cycle_cpu: directed program table plus
// hand-written branch, halt and reset sequences.
module tb_single_cycle_cpu;

   logic        CLK = 1'b0;
   logic        Reset;
   logic [31:0] PCout, PCin, PCValue, instruction;
   logic [5:0]  op;
   logic [4:0]  rs, rt, rd, RFSelectorOut;
   logic [15:0] immediate;
   logic        zero, RegOut, InsMenRW, ExtSel, DataMenRW, ALUM2Reg;
   logic        ALUSrcB, PCSrc, RegWre, PCWre;
   logic [2:0]  ALUOp;
   logic [31:0] extendOut, readData1, readData2, ALUSelectorOut;
   logic [31:0] result, dataOut, writeData;

   int checks = 0;
   int errors = 0;

   single_cycle_cpu dut (
      .CLK(CLK), .Reset(Reset), .PCout(PCout), .PCin(PCin),
      .PCValue(PCValue), .instruction(instruction), .op(op), .rs(rs),
      .rt(rt), .rd(rd), .immediate(immediate), .zero(zero),
      .RegOut(RegOut), .InsMenRW(InsMenRW), .ExtSel(ExtSel),
      .DataMenRW(DataMenRW), .ALUM2Reg(ALUM2Reg), .ALUSrcB(ALUSrcB),
      .PCSrc(PCSrc), .RegWre(RegWre), .PCWre(PCWre), .ALUOp(ALUOp),
      .RFSelectorOut(RFSelectorOut), .extendOut(extendOut),
      .readData1(readData1), .readData2(readData2),
      .ALUSelectorOut(ALUSelectorOut), .result(result),
      .dataOut(dataOut), .writeData(writeData)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
      logic [31:0] pcin;
      logic [7:0]  ctl;   // RegWre,ALUSrcB,ExtSel,RegOut,ALUM2Reg,DataMenRW,PCSrc,PCWre
      logic [2:0]  aluop;
      logic [31:0] res;
      logic [31:0] wd;
      logic [4:0]  dst;
   } vec_t;

   vec_t tv [9];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      tv[0] = '{32'h00, 32'h04010008, 32'h04, 8'b11100001, 3'd0, 32'd8,  32'd8,  5'd1};
      tv[1] = '{32'h04, 32'h40020002, 32'h08, 8'b11000001, 3'd3, 32'd2,  32'd2,  5'd2};
      tv[2] = '{32'h08, 32'h00221800, 32'h0C, 8'b10010001, 3'd0, 32'd10, 32'd10, 5'd3};
      tv[3] = '{32'h0C, 32'h08222000, 32'h10, 8'b10010001, 3'd1, 32'd6,  32'd6,  5'd4};
      tv[4] = '{32'h10, 32'h44222800, 32'h14, 8'b10010001, 3'd2, 32'd0,  32'd0,  5'd5};
      tv[5] = '{32'h14, 32'h48223000, 32'h18, 8'b10010001, 3'd3, 32'd10, 32'd10, 5'd6};
      tv[6] = '{32'h18, 32'h98010004, 32'h1C, 8'b01100101, 3'd0, 32'd4,  32'd4,  5'd1};
      tv[7] = '{32'h1C, 32'h9C070004, 32'h20, 8'b11101001, 3'd0, 32'd4,  32'd8,  5'd7};
      tv[8] = '{32'h20, 32'hC027FFFE, 32'h1C, 8'b00100011, 3'd1, 32'd0,  32'd0,  5'd7};

      Reset = 1'b1;
      #1;
      for (int i = 0; i < 9; i++) dut.imem[i] = tv[i].ins;
      dut.imem[9]  = 32'h04000005;   // addi $0,$0,5
      dut.imem[10] = 32'hFC000000;   // halt

      step();
      Reset = 1'b0;
      chk("reset_pc", PCout, 32'h0);
      chk("reset_pcvalue", PCValue, 32'h4);
      chk("reset_rd1", readData1, 32'h0);
      chk("reset_insmen", {31'd0, InsMenRW}, 32'h0);

      for (int i = 0; i < 9; i++) begin
         chk($sformatf("pc[%0d]", i), PCout, tv[i].pc);
         chk($sformatf("ins[%0d]", i), instruction, tv[i].ins);
         chk($sformatf("pcin[%0d]", i), PCin, tv[i].pcin);
         chk($sformatf("ctl[%0d]", i),
             {24'd0, RegWre, ALUSrcB, ExtSel, RegOut, ALUM2Reg,
              DataMenRW, PCSrc, PCWre}, {24'd0, tv[i].ctl});
         chk($sformatf("aluop[%0d]", i), {29'd0, ALUOp}, {29'd0, tv[i].aluop});
         chk($sformatf("result[%0d]", i), result, tv[i].res);
         chk($sformatf("wdata[%0d]", i), writeData, tv[i].wd);
         chk($sformatf("dst[%0d]", i), {27'd0, RFSelectorOut}, {27'd0, tv[i].dst});
         step();
      end

      chk("beq_taken_pc", PCout, 32'h1C);
      chk("rf1", dut.rf[1], 32'd8);
      chk("rf2", dut.rf[2], 32'd2);
      chk("rf3", dut.rf[3], 32'd10);
      chk("rf4", dut.rf[4], 32'd6);
      chk("rf5", dut.rf[5], 32'd0);
      chk("rf6", dut.rf[6], 32'd10);
      chk("rf7", dut.rf[7], 32'd8);
      chk("lw_again_dataout", dataOut, 32'd8);

      // replace the looping beq with beq $1,$2,-2 (operands differ)
      dut.imem[8] = 32'hC022FFFE;
      step();
      chk("beq_nt_pc", PCout, 32'h20);
      chk("beq_nt_zero", {31'd0, zero}, 32'd0);
      chk("beq_nt_pcsrc", {31'd0, PCSrc}, 32'd0);
      chk("beq_nt_pcin", PCin, 32'h24);
      step();
      chk("addi0_pc", PCout, 32'h24);
      chk("addi0_dst", {27'd0, RFSelectorOut}, 32'd0);
      step();
      chk("rf0_zero", dut.rf[0], 32'd0);
      chk("halt_pc", PCout, 32'h28);
      chk("halt_pcwre", {31'd0, PCWre}, 32'd0);
      chk("halt_regwre", {31'd0, RegWre}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("halt_hold[%0d]", i), PCout, 32'h28);
      end

      // bne $1,$0,3 with both operands 0 after reset, then lw from preserved RAM
      dut.imem[0] = 32'hC4200003;
      dut.imem[1] = 32'h9C080004;
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      chk("rst2_pc", PCout, 32'h0);
      chk("rst2_rf1", dut.rf[1], 32'd0);
      chk("rst2_rf7", dut.rf[7], 32'd0);
      chk("op110001_pcsrc", {31'd0, PCSrc}, 32'd0);
      chk("op110001_pcin", PCin, 32'h4);
      chk("op110001_wr", {30'd0, RegWre, DataMenRW}, 32'd0);
      step();
      chk("rst2_lw_pc", PCout, 32'h4);
      chk("dmem_kept", dataOut, 32'd8);
      chk("dmem_kept_wd", writeData, 32'd8);
      step();
      chk("rf8", dut.rf[8], 32'd8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
